// File: rtl/axi4_lite_master_pkg.sv
// rtl/axi4_lite_master_pkg.sv - shared widths, channel state and response codes for the AXI4-Lite master
package axi4_lite_master_pkg;

  localparam int Addr_Width = 32;
  localparam int Data_Width = 32;

  // Both channel FSMs walk the same four phases.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b10,
    RESP = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

endpackage

// File: rtl/axi4_lite_master.sv
// rtl/axi4_lite_master.sv - host request to AXI4-Lite bridge with independent write and read FSMs
module axi4_lite_master
  import axi4_lite_master_pkg::*;
#(
  parameter int ADDR_WIDTH = Addr_Width,
  parameter int DATA_WIDTH = Data_Width
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic                      start_write,
  input  logic                      start_read,
  input  logic [ADDR_WIDTH-1:0]     host_addr,
  input  logic [DATA_WIDTH-1:0]     host_wdata,
  input  logic [DATA_WIDTH/8-1:0]   host_wstrb,
  output logic                      wr_busy,
  output logic                      rd_busy,
  output logic                      wr_done,
  output logic [1:0]                wr_resp,
  output logic                      rd_done,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic [1:0]                rd_resp,
  output logic [ADDR_WIDTH-1:0]     AWADDR,
  output logic [2:0]                AWPROT,
  output logic                      AWVALID,
  input  logic                      AWREADY,
  output logic [DATA_WIDTH-1:0]     WDATA,
  output logic [DATA_WIDTH/8-1:0]   WSTRB,
  output logic                      WVALID,
  input  logic                      WREADY,
  input  logic [1:0]                BRESP,
  input  logic                      BVALID,
  output logic                      BREADY,
  output logic [ADDR_WIDTH-1:0]     ARADDR,
  output logic [2:0]                ARPROT,
  output logic                      ARVALID,
  input  logic                      ARREADY,
  input  logic [DATA_WIDTH-1:0]     RDATA,
  input  logic [1:0]                RRESP,
  input  logic                      RVALID,
  output logic                      RREADY
);

  state_t wr_state;
  state_t rd_state;

  // Write channel: address phase, then data phase, then wait for the write response.
  // AWADDR/WDATA/WSTRB are only loaded in IDLE, so they stay stable while VALIDs are up.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_state <= IDLE;
      AWADDR   <= '0;
      WDATA    <= '0;
      WSTRB    <= '0;
      wr_resp  <= OKAY;
      wr_done  <= 1'b0;
    end else begin
      wr_done <= 1'b0;
      case (wr_state)
        IDLE: begin
          if (start_write) begin
            AWADDR   <= host_addr;
            WDATA    <= host_wdata;
            WSTRB    <= host_wstrb;
            wr_state <= ADDR;
          end
        end
        ADDR: begin
          if (AWREADY) wr_state <= DATA;
        end
        DATA: begin
          if (WREADY) wr_state <= RESP;
        end
        RESP: begin
          if (BVALID) begin
            wr_resp  <= BRESP;
            wr_done  <= 1'b1;
            wr_state <= IDLE;
          end
        end
      endcase
    end
  end

  // Read channel: address phase, wait for read data, then one RESP cycle to signal completion.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rd_state <= IDLE;
      ARADDR   <= '0;
      rd_data  <= '0;
      rd_resp  <= OKAY;
      rd_done  <= 1'b0;
    end else begin
      rd_done <= 1'b0;
      case (rd_state)
        IDLE: begin
          if (start_read) begin
            ARADDR   <= host_addr;
            rd_state <= ADDR;
          end
        end
        ADDR: begin
          if (ARREADY) rd_state <= DATA;
        end
        DATA: begin
          if (RVALID) begin
            rd_data  <= RDATA;
            rd_resp  <= RRESP;
            rd_done  <= 1'b1;
            rd_state <= RESP;
          end
        end
        RESP: begin
          rd_state <= IDLE;
        end
      endcase
    end
  end

  // Channel handshake signals decode the registered state only, so no input reaches them combinationally.
  assign AWVALID = (wr_state == ADDR);
  assign WVALID  = (wr_state == DATA);
  assign BREADY  = (wr_state == RESP);
  assign ARVALID = (rd_state == ADDR);
  assign RREADY  = (rd_state == DATA);
  assign wr_busy = (wr_state != IDLE);
  assign rd_busy = (rd_state != IDLE);
  assign AWPROT  = 3'b000;
  assign ARPROT  = 3'b000;

endmodule

// File: tb/tb_axi4_lite_master.sv
// tb/tb_axi4_lite_master.sv - randomized and directed self-checking bench for axi4_lite_master
module tb_axi4_lite_master;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        start_write = 1'b0, start_read = 1'b0;
  logic [31:0] host_addr = '0, host_wdata = '0;
  logic [3:0]  host_wstrb = '0;
  logic        wr_busy, rd_busy, wr_done, rd_done;
  logic [1:0]  wr_resp, rd_resp;
  logic [31:0] rd_data;
  logic [31:0] AWADDR, WDATA, ARADDR;
  logic [2:0]  AWPROT, ARPROT;
  logic [3:0]  WSTRB;
  logic        AWVALID, WVALID, BREADY, ARVALID, RREADY;
  logic        AWREADY = 1'b0, WREADY = 1'b0, BVALID = 1'b0, ARREADY = 1'b0, RVALID = 1'b0;
  logic [1:0]  BRESP = '0, RRESP = '0;
  logic [31:0] RDATA = '0;

  axi4_lite_master dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .start_write(start_write), .start_read(start_read),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_wstrb(host_wstrb),
    .wr_busy(wr_busy), .rd_busy(rd_busy),
    .wr_done(wr_done), .wr_resp(wr_resp),
    .rd_done(rd_done), .rd_data(rd_data), .rd_resp(rd_resp),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  int total = 0;
  int bad = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: one outstanding write and one outstanding read, each tracked
  // as "which handshakes have completed so far".
  logic        m_wact, m_aw, m_w, m_wr_done;
  logic [1:0]  m_wr_resp;
  logic [31:0] m_awaddr, m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_ract, m_ar, m_got, m_rd_done;
  logic [1:0]  m_rd_resp;
  logic [31:0] m_araddr, m_rd_data;

  always @(posedge ACLK) begin
    if (ARESET) begin
      m_wact <= 0; m_aw <= 0; m_w <= 0; m_wr_done <= 0; m_wr_resp <= 0;
      m_awaddr <= 0; m_wdata <= 0; m_wstrb <= 0;
      m_ract <= 0; m_ar <= 0; m_got <= 0; m_rd_done <= 0; m_rd_resp <= 0;
      m_araddr <= 0; m_rd_data <= 0;
    end else begin
      m_wr_done <= 0;
      if (m_wact) begin
        if (!m_aw) begin
          if (AWREADY) m_aw <= 1;
        end else if (!m_w) begin
          if (WREADY) m_w <= 1;
        end else if (BVALID) begin
          m_wr_resp <= BRESP; m_wr_done <= 1; m_wact <= 0;
        end
      end else if (start_write) begin
        m_wact <= 1; m_aw <= 0; m_w <= 0;
        m_awaddr <= host_addr; m_wdata <= host_wdata; m_wstrb <= host_wstrb;
      end
      m_rd_done <= 0;
      if (m_ract) begin
        if (!m_ar) begin
          if (ARREADY) m_ar <= 1;
        end else if (!m_got) begin
          if (RVALID) begin
            m_got <= 1; m_rd_data <= RDATA; m_rd_resp <= RRESP; m_rd_done <= 1;
          end
        end else begin
          m_ract <= 0;
        end
      end else if (start_read) begin
        m_ract <= 1; m_ar <= 0; m_got <= 0; m_araddr <= host_addr;
      end
    end
  end

  // Compare every DUT output against the reference once per cycle, away from the active edge.
  always @(negedge ACLK) begin
    if (chk_en) begin
      chk("wr_busy", wr_busy, m_wact);
      chk("rd_busy", rd_busy, m_ract);
      chk("AWVALID", AWVALID, m_wact && !m_aw);
      chk("WVALID", WVALID, m_wact && m_aw && !m_w);
      chk("BREADY", BREADY, m_wact && m_w);
      chk("ARVALID", ARVALID, m_ract && !m_ar);
      chk("RREADY", RREADY, m_ract && m_ar && !m_got);
      chk("wr_done", wr_done, m_wr_done);
      chk("wr_resp", wr_resp, m_wr_resp);
      chk("rd_done", rd_done, m_rd_done);
      chk("rd_data", rd_data, m_rd_data);
      chk("rd_resp", rd_resp, m_rd_resp);
      chk("AWADDR", AWADDR, m_awaddr);
      chk("WDATA", WDATA, m_wdata);
      chk("WSTRB", WSTRB, m_wstrb);
      chk("ARADDR", ARADDR, m_araddr);
      chk("PROT", {AWPROT, ARPROT}, 6'd0);
    end
  end

  // Slave bookkeeping: a write response is owed after a W handshake, read data after an AR handshake.
  logic b_pend = 0, r_pend = 0;
  int   aw_hs = 0;
  always @(posedge ACLK) begin
    if (ARESET) begin
      b_pend <= 0; r_pend <= 0;
    end else begin
      if (WVALID && WREADY) b_pend <= 1;
      else if (BVALID && BREADY) b_pend <= 0;
      if (ARVALID && ARREADY) r_pend <= 1;
      else if (RVALID && RREADY) r_pend <= 0;
      if (AWVALID && AWREADY) aw_hs <= aw_hs + 1;
    end
  end

  task automatic cyc();
    @(posedge ACLK);
    #1;
  endtask

  task automatic drive_slave();
    AWREADY = 1'($urandom_range(0, 1));
    WREADY  = 1'($urandom_range(0, 1));
    ARREADY = 1'($urandom_range(0, 1));
    if (!b_pend) BVALID = 0;
    else if (!BVALID) begin
      BVALID = 1'($urandom_range(0, 1));
      BRESP  = 2'($urandom);
    end
    if (!r_pend) RVALID = 0;
    else if (!RVALID) begin
      RVALID = 1'($urandom_range(0, 1));
      RDATA  = $urandom;
      RRESP  = 2'($urandom);
    end
  endtask

  task automatic idle(input int n);
    start_write = 0; start_read = 0;
    AWREADY = 0; WREADY = 0; ARREADY = 0; BVALID = 0; RVALID = 0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    logic gw, gr;
    int   base;

    ARESET = 1;
    cyc();
    chk_en = 1;
    cyc();
    ARESET = 0;
    chk("rst_awvalid", AWVALID, 1'b0);
    chk("rst_wr_busy", wr_busy, 1'b0);
    chk("rst_rd_data", rd_data, 32'h0);
    chk("rst_awaddr", AWADDR, 32'h0);

    // Zero-wait write.
    start_write = 1; host_addr = 32'h10; host_wdata = 32'hDEADBEEF; host_wstrb = 4'hF;
    AWREADY = 1; WREADY = 1;
    cyc();
    start_write = 0;
    chk("t1_awvalid_c1", AWVALID, 1'b1);
    chk("t1_awaddr_c1", AWADDR, 32'h10);
    cyc();
    chk("t1_wvalid_c2", WVALID, 1'b1);
    chk("t1_wdata_c2", WDATA, 32'hDEADBEEF);
    cyc();
    chk("t1_bready_c3", BREADY, 1'b1);
    BVALID = 1; BRESP = 2'b00;
    cyc();
    chk("t1_wr_done_c4", wr_done, 1'b1);
    chk("t1_wr_resp_c4", wr_resp, 2'b00);
    chk("t1_wr_busy_c4", wr_busy, 1'b0);
    idle(2);

    // Slow slave: AWREADY low 3 cycles, WREADY low 2 cycles, late DECERR response.
    start_write = 1; host_addr = 32'h44; host_wdata = 32'hCAFE0001; host_wstrb = 4'h3;
    cyc();
    start_write = 0;
    for (int i = 0; i < 3; i++) begin
      chk("t2_awvalid_hold", AWVALID, 1'b1);
      chk("t2_awaddr_hold", AWADDR, 32'h44);
      chk("t2_wvalid_early", WVALID, 1'b0);
      cyc();
    end
    AWREADY = 1;
    cyc();
    AWREADY = 0;
    for (int i = 0; i < 2; i++) begin
      chk("t2_wvalid_hold", WVALID, 1'b1);
      cyc();
    end
    WREADY = 1;
    cyc();
    WREADY = 0;
    chk("t2_bready", BREADY, 1'b1);
    cyc();
    chk("t2_no_early_done", wr_done, 1'b0);
    BVALID = 1; BRESP = 2'b11;
    cyc();
    BVALID = 0;
    chk("t2_wr_done", wr_done, 1'b1);
    chk("t2_wr_resp", wr_resp, 2'b11);
    cyc();
    chk("t2_done_one_cycle", wr_done, 1'b0);
    chk("t2_resp_hold", wr_resp, 2'b11);
    idle(2);

    // Read with two wait cycles returning SLVERR.
    start_read = 1; host_addr = 32'h20; ARREADY = 1;
    cyc();
    start_read = 0;
    chk("t3_arvalid", ARVALID, 1'b1);
    chk("t3_araddr", ARADDR, 32'h20);
    cyc();
    ARREADY = 0;
    chk("t3_rready", RREADY, 1'b1);
    cyc();
    cyc();
    RVALID = 1; RDATA = 32'h12345678; RRESP = 2'b10;
    cyc();
    RVALID = 0;
    chk("t3_rd_done", rd_done, 1'b1);
    chk("t3_rd_data", rd_data, 32'h12345678);
    chk("t3_rd_resp", rd_resp, 2'b10);
    cyc();
    chk("t3_rd_done_off", rd_done, 1'b0);
    chk("t3_rd_data_hold", rd_data, 32'h12345678);
    idle(2);

    // Simultaneous read and write.
    start_write = 1; start_read = 1; host_addr = 32'h88; host_wdata = 32'h5555AAAA; host_wstrb = 4'hC;
    cyc();
    start_write = 0; start_read = 0;
    chk("t4_both_valid", {AWVALID, ARVALID}, 2'b11);
    gw = 0; gr = 0;
    for (int i = 0; i < 80 && !(gw && gr); i++) begin
      drive_slave();
      cyc();
      if (wr_done) gw = 1;
      if (rd_done) gr = 1;
    end
    chk("t4_wr_done_seen", gw, 1'b1);
    chk("t4_rd_done_seen", gr, 1'b1);
    idle(3);

    // Second start_write while busy is dropped.
    base = aw_hs;
    start_write = 1; host_addr = 32'h100; host_wdata = 32'h1; host_wstrb = 4'h1;
    cyc();
    host_addr = 32'h200; host_wdata = 32'h2;
    cyc();
    cyc();
    start_write = 0;
    chk("t5_awaddr_kept", AWADDR, 32'h100);
    gw = 0;
    for (int i = 0; i < 80 && !gw; i++) begin
      drive_slave();
      cyc();
      if (wr_done) gw = 1;
    end
    chk("t5_wr_done_seen", gw, 1'b1);
    idle(3);
    chk("t5_one_aw_handshake", aw_hs - base, 1);

    // Reset while the write sits in its data phase.
    start_write = 1; host_addr = 32'h300; host_wdata = 32'h3; host_wstrb = 4'hF; AWREADY = 1;
    cyc();
    start_write = 0;
    cyc();
    AWREADY = 0;
    chk("t6_in_data", WVALID, 1'b1);
    ARESET = 1;
    cyc();
    ARESET = 0;
    chk("t6_valids_low", {AWVALID, WVALID, BREADY}, 3'b000);
    chk("t6_wr_busy", wr_busy, 1'b0);
    gw = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (wr_done) gw = 1;
    end
    chk("t6_no_wr_done", gw, 1'b0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      drive_slave();
      start_write = ($urandom_range(0, 3) == 0);
      start_read  = ($urandom_range(0, 3) == 0);
      host_addr   = $urandom;
      host_wdata  = $urandom;
      host_wstrb  = 4'($urandom);
      ARESET      = ($urandom_range(0, 299) == 0);
      if (ARESET) begin
        BVALID = 0; RVALID = 0;
      end
      cyc();
    end
    ARESET = 0;
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
